// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the I-cache and D-cache request ports plus
// the line-wide Avalon burst master port. The master modport is the arbiter
// view; the slave modport is the view of the caches and interconnect around it.
interface mem_port_arbiter_if #(
  parameter int LINE_W = 128
);
  // I-cache refill port
  logic              i_req;
  logic [31:0]       i_address;
  logic              i_ack;
  logic [LINE_W-1:0] i_rdata;
  // D-cache refill/writeback port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ack;
  logic [LINE_W-1:0] d_rdata;
  // Avalon burst master
  logic [31:0]       av_address;
  logic              av_read;
  logic              av_write;
  logic [LINE_W-1:0] av_writedata;
  logic [2:0]        av_burstcount;
  logic              av_wait_data;
  logic              av_readdatavalid;
  logic [LINE_W-1:0] av_reddata;

  modport master (
    input  i_req, i_address, d_req, d_we, d_address, d_wdata,
           av_wait_data, av_readdatavalid, av_reddata,
    output i_ack, i_rdata, d_ack, d_rdata,
           av_address, av_read, av_write, av_writedata, av_burstcount
  );

  modport slave (
    output i_req, i_address, d_req, d_we, d_address, d_wdata,
           av_wait_data, av_readdatavalid, av_reddata,
    input  i_ack, i_rdata, d_ack, d_rdata,
           av_address, av_read, av_write, av_writedata, av_burstcount
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon burst master between the I-cache refill
// path and the D-cache refill/writeback path. One transaction is in flight at a
// time; the owner receives its line and a one-cycle ack when it completes.
// Ties are broken round robin by default. Defining ARB_DCACHE_PRIORITY_EN
// makes the D-cache win every tie instead.
module mem_port_arbiter #(
  parameter logic [2:0] BURST = 3'h4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int LINE_W = 32 * int'(BURST);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, DONE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_owner_q, last_owner_d;
  owner_t            grant;
  logic              is_write_q, is_write_d;
  logic              av_read_q, av_read_d;
  logic              av_write_q, av_write_d;
  logic [31:0]       av_address_q, av_address_d;
  logic [LINE_W-1:0] av_writedata_q, av_writedata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              capture;
  logic              finish;

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_I;
      last_owner_q   <= OWN_D;
      is_write_q     <= 1'b0;
      av_read_q      <= 1'b0;
      av_write_q     <= 1'b0;
      av_address_q   <= '0;
      av_writedata_q <= '0;
      i_ack_q        <= 1'b0;
      d_ack_q        <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      is_write_q     <= is_write_d;
      av_read_q      <= av_read_d;
      av_write_q     <= av_write_d;
      av_address_q   <= av_address_d;
      av_writedata_q <= av_writedata_d;
      i_ack_q        <= i_ack_d;
      d_ack_q        <= d_ack_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  // Arbitration, command sequencing, read capture and ack generation.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    is_write_d     = is_write_q;
    av_read_d      = av_read_q;
    av_write_d     = av_write_q;
    av_address_d   = av_address_q;
    av_writedata_d = av_writedata_q;
    i_ack_d        = 1'b0;
    d_ack_d        = 1'b0;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    grant          = OWN_I;
    capture        = 1'b0;
    finish         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          if (bus.i_req && bus.d_req) begin
`ifdef ARB_DCACHE_PRIORITY_EN
            grant = OWN_D;
`else
            // Whoever did not own the port last time wins the tie.
            grant = (last_owner_q == OWN_D) ? OWN_I : OWN_D;
`endif
          end else begin
            grant = bus.d_req ? OWN_D : OWN_I;
          end
          owner_d      = grant;
          last_owner_d = grant;
          state_d      = CMD;
          if (grant == OWN_D) begin
            av_address_d = bus.d_address;
            is_write_d   = bus.d_we;
            av_read_d    = ~bus.d_we;
            av_write_d   = bus.d_we;
            if (bus.d_we) begin
              av_writedata_d = bus.d_wdata;
            end
          end else begin
            av_address_d = bus.i_address;
            is_write_d   = 1'b0;
            av_read_d    = 1'b1;
            av_write_d   = 1'b0;
          end
        end
      end
      CMD: begin
        // Command is held until the first cycle without waitrequest.
        if (!bus.av_wait_data) begin
          av_read_d  = 1'b0;
          av_write_d = 1'b0;
          if (is_write_q) begin
            finish = 1'b1;
          end else if (bus.av_readdatavalid) begin
            capture = 1'b1;
          end else begin
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (bus.av_readdatavalid) begin
          capture = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      finish = 1'b1;
      if (owner_q == OWN_D) begin
        d_rdata_d = bus.av_reddata;
      end else begin
        i_rdata_d = bus.av_reddata;
      end
    end

    // The ack register is set on entry to DONE so it is high for that cycle only.
    if (finish) begin
      state_d = DONE;
      i_ack_d = (owner_q == OWN_I);
      d_ack_d = (owner_q == OWN_D);
    end
  end

  assign bus.av_address    = av_address_q;
  assign bus.av_read       = av_read_q;
  assign bus.av_write      = av_write_q;
  assign bus.av_writedata  = av_writedata_q;
  assign bus.av_burstcount = BURST;
  assign bus.i_ack         = i_ack_q;
  assign bus.d_ack         = d_ack_q;
  assign bus.i_rdata       = i_rdata_q;
  assign bus.d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [LINE_W-1:0] last_i_line;

  mem_port_arbiter_if #(.LINE_W(LINE_W)) bus ();

  mem_port_arbiter #(.BURST(3'h4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b0) begin n_fail++; $display("FAIL reset av_read got %b exp 0", bus.av_read); end
    n_checks++; if (bus.av_write !== 1'b0) begin n_fail++; $display("FAIL reset av_write got %b exp 0", bus.av_write); end
    n_checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL reset acks got %b%b exp 00", bus.i_ack, bus.d_ack); end
    n_checks++; if (bus.av_address !== 32'h0) begin n_fail++; $display("FAIL reset av_address got %h exp 0", bus.av_address); end
    n_checks++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0 || bus.av_writedata !== '0) begin n_fail++; $display("FAIL reset data regs not zero i=%h d=%h w=%h", bus.i_rdata, bus.d_rdata, bus.av_writedata); end
    n_checks++; if (bus.av_burstcount !== 3'd4) begin n_fail++; $display("FAIL reset av_burstcount got %0d exp 4", bus.av_burstcount); end
    reset = 1'b0;
  endtask

  task automatic test_icache_alone();
    logic [LINE_W-1:0] line;
    line = 128'h11111111_22222222_33333333_DEADBEEF;
    @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b0) begin n_fail++; $display("FAIL icache av_read before grant got %b exp 0", bus.av_read); end
    bus.i_req = 1'b1; bus.i_address = 32'h0000_0100; bus.av_wait_data = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_checks++; if (bus.av_read !== (c == 1)) begin n_fail++; $display("FAIL icache av_read c=%0d got %b exp %b", c, bus.av_read, (c == 1)); end
      n_checks++; if (bus.i_ack !== (c == 5)) begin n_fail++; $display("FAIL icache i_ack c=%0d got %b exp %b", c, bus.i_ack, (c == 5)); end
      n_checks++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL icache d_ack c=%0d got %b exp 0", c, bus.d_ack); end
      if (c == 1) begin
        n_checks++; if (bus.av_address !== 32'h100) begin n_fail++; $display("FAIL icache av_address got %h exp 00000100", bus.av_address); end
        n_checks++; if (bus.av_burstcount !== 3'd4) begin n_fail++; $display("FAIL icache av_burstcount got %0d exp 4", bus.av_burstcount); end
      end
      if (c == 5) begin
        n_checks++; if (bus.i_rdata !== line) begin n_fail++; $display("FAIL icache i_rdata got %h exp %h", bus.i_rdata, line); end
        bus.i_req = 1'b0;
      end
      bus.av_readdatavalid = (c == 4);
      bus.av_reddata       = (c == 4) ? line : '0;
    end
    last_i_line = line;
  endtask

  task automatic test_dcache_write_stall();
    logic [LINE_W-1:0] pat;
    pat = 128'hA5A5A5A5_0F0F0F0F_12345678_CAFEF00D;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_address = 32'h200; bus.d_wdata = pat;
    bus.av_wait_data = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_checks++; if (bus.av_write !== (c <= 6)) begin n_fail++; $display("FAIL dwrite av_write c=%0d got %b exp %b", c, bus.av_write, (c <= 6)); end
      n_checks++; if (bus.av_read !== 1'b0) begin n_fail++; $display("FAIL dwrite av_read c=%0d got %b exp 0", c, bus.av_read); end
      n_checks++; if (bus.d_ack !== (c == 7)) begin n_fail++; $display("FAIL dwrite d_ack c=%0d got %b exp %b", c, bus.d_ack, (c == 7)); end
      n_checks++; if (bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL dwrite i_ack c=%0d got %b exp 0", c, bus.i_ack); end
      if (c <= 6) begin
        n_checks++; if (bus.av_writedata !== pat) begin n_fail++; $display("FAIL dwrite av_writedata c=%0d got %h exp %h", c, bus.av_writedata, pat); end
        n_checks++; if (bus.av_address !== 32'h200) begin n_fail++; $display("FAIL dwrite av_address c=%0d got %h exp 00000200", c, bus.av_address); end
      end
      if (c == 7) bus.d_req = 1'b0;
      bus.av_wait_data = (c <= 5);
    end
    bus.d_we = 1'b0;
  endtask

  task automatic test_contention();
    logic              exp_d;
    logic [LINE_W-1:0] line;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_address = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_address = 32'h400;
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_DCACHE_PRIORITY_EN
      exp_d = 1'b1;
`else
      exp_d = (r % 2 == 1);
`endif
      line = {96'h0BAD_0000_0000_0000_0000_0000, 28'h0, r[3:0]} ^ (exp_d ? 128'hD : 128'hE0);
      @(negedge clk);
      n_checks++; if (bus.av_read !== 1'b1) begin n_fail++; $display("FAIL contention av_read r=%0d got %b exp 1", r, bus.av_read); end
      n_checks++; if (bus.av_address !== (exp_d ? 32'h400 : 32'h300)) begin n_fail++; $display("FAIL contention grant r=%0d av_address got %h exp %h", r, bus.av_address, (exp_d ? 32'h400 : 32'h300)); end
      bus.av_readdatavalid = 1'b1; bus.av_reddata = line;
      @(negedge clk);
      n_checks++; if (bus.i_ack !== ~exp_d || bus.d_ack !== exp_d) begin n_fail++; $display("FAIL contention ack r=%0d got i=%b d=%b exp i=%b d=%b", r, bus.i_ack, bus.d_ack, ~exp_d, exp_d); end
      n_checks++; if ((exp_d ? bus.d_rdata : bus.i_rdata) !== line) begin n_fail++; $display("FAIL contention rdata r=%0d got %h exp %h", r, (exp_d ? bus.d_rdata : bus.i_rdata), line); end
      if (!exp_d) last_i_line = line;
      bus.av_readdatavalid = 1'b0; bus.av_reddata = '0;
      if (exp_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      @(negedge clk);
      if (r < 3) begin
        if (exp_d) bus.d_req = 1'b1; else bus.i_req = 1'b1;
      end else begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b0) begin n_fail++; $display("FAIL contention idle av_read got %b exp 0", bus.av_read); end
  endtask

  task automatic test_accept_rdv();
    logic [LINE_W-1:0] line;
    line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_address = 32'h700; bus.av_wait_data = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b1 || bus.av_write !== 1'b0) begin n_fail++; $display("FAIL accept_rdv command got rd=%b wr=%b exp rd=1 wr=0", bus.av_read, bus.av_write); end
    n_checks++; if (bus.av_address !== 32'h700) begin n_fail++; $display("FAIL accept_rdv av_address got %h exp 00000700", bus.av_address); end
    bus.av_readdatavalid = 1'b1; bus.av_reddata = line;
    @(negedge clk);
    n_checks++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL accept_rdv ack got d=%b i=%b exp d=1 i=0", bus.d_ack, bus.i_ack); end
    n_checks++; if (bus.d_rdata !== line) begin n_fail++; $display("FAIL accept_rdv d_rdata got %h exp %h", bus.d_rdata, line); end
    n_checks++; if (bus.i_rdata !== last_i_line) begin n_fail++; $display("FAIL accept_rdv i_rdata hold got %h exp %h", bus.i_rdata, last_i_line); end
    bus.d_req = 1'b0; bus.av_readdatavalid = 1'b0; bus.av_reddata = '0;
    @(negedge clk);
    n_checks++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL accept_rdv d_ack width got %b exp 0", bus.d_ack); end
    @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b0) begin n_fail++; $display("FAIL accept_rdv extra av_read got %b exp 0", bus.av_read); end
  endtask

  task automatic test_reset_rdwait();
    logic [LINE_W-1:0] line;
    line = 128'h5555_AAAA_5555_AAAA_0000_FFFF_0000_FFFF;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_address = 32'h800; bus.av_wait_data = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b1) begin n_fail++; $display("FAIL rst_rdwait av_read got %b exp 1", bus.av_read); end
    @(negedge clk);
    reset = 1'b1; bus.i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (bus.av_read !== 1'b0 || bus.av_write !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_rdwait controls got rd=%b wr=%b ia=%b da=%b exp 0000", bus.av_read, bus.av_write, bus.i_ack, bus.d_ack); end
    n_checks++; if (bus.av_address !== 32'h0 || bus.i_rdata !== '0 || bus.d_rdata !== '0 || bus.av_writedata !== '0) begin n_fail++; $display("FAIL rst_rdwait data got addr=%h i=%h d=%h exp 0", bus.av_address, bus.i_rdata, bus.d_rdata); end
    bus.av_readdatavalid = 1'b1; bus.av_reddata = line;
    @(negedge clk);
    bus.av_readdatavalid = 1'b0; bus.av_reddata = '0;
    n_checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.i_rdata !== '0) begin n_fail++; $display("FAIL rst_rdwait late rdv got ia=%b da=%b i_rdata=%h exp 0", bus.i_ack, bus.d_ack, bus.i_rdata); end
    bus.i_req = 1'b1; bus.i_address = 32'h900;
    @(negedge clk);
    n_checks++; if (bus.av_read !== 1'b1 || bus.av_address !== 32'h900) begin n_fail++; $display("FAIL rst_rdwait regrant got rd=%b addr=%h exp rd=1 addr=00000900", bus.av_read, bus.av_address); end
    bus.av_readdatavalid = 1'b1; bus.av_reddata = ~line;
    @(negedge clk);
    n_checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== ~line) begin n_fail++; $display("FAIL rst_rdwait regrant ack got ia=%b data=%h exp ia=1 data=%h", bus.i_ack, bus.i_rdata, ~line); end
    last_i_line = ~line;
    bus.i_req = 1'b0; bus.av_readdatavalid = 1'b0; bus.av_reddata = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_held_request();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_address = 32'h600; bus.av_wait_data = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++; if (bus.av_read !== (c == 1 || c == 4)) begin n_fail++; $display("FAIL held_req av_read c=%0d got %b exp %b", c, bus.av_read, (c == 1 || c == 4)); end
      n_checks++; if (bus.i_ack !== (c == 2 || c == 5)) begin n_fail++; $display("FAIL held_req i_ack c=%0d got %b exp %b", c, bus.i_ack, (c == 2 || c == 5)); end
      if (c == 4) begin
        n_checks++; if (bus.av_address !== 32'h600) begin n_fail++; $display("FAIL held_req av_address got %h exp 00000600", bus.av_address); end
        bus.i_req = 1'b0;
      end
      bus.av_readdatavalid = (c == 1 || c == 4);
      bus.av_reddata       = (c == 1 || c == 4) ? 128'h600 : '0;
    end
  endtask

  initial begin
    reset                = 1'b1;
    bus.i_req            = 1'b0;
    bus.i_address        = '0;
    bus.d_req            = 1'b0;
    bus.d_we             = 1'b0;
    bus.d_address        = '0;
    bus.d_wdata          = '0;
    bus.av_wait_data     = 1'b0;
    bus.av_readdatavalid = 1'b0;
    bus.av_reddata       = '0;
    last_i_line          = '0;
    test_reset();
    test_icache_alone();
    test_dcache_write_stall();
    test_contention();
    test_accept_rdv();
    test_reset_rdwait();
    test_held_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single line-wide Avalon burst master port between the instruction cache refill path and the data cache refill/writeback path.
- Arbitrates between the two requesters, registers the winning command onto the Avalon bus, and tracks the transfer to completion.
- Returns the line and a one-cycle acknowledge to the owning requester.
- Sits between the I-cache/D-cache controllers and the memory interconnect.

Parameters:
- BURST, 3'h4, beats per line transfer; driven on av_burstcount.
- LINE_W, BURST*32, width of a cache line in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  I-cache line-read request; held high until i_ack.
- i_address  in  32  I-cache line address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; the I-cache line is complete.
- i_rdata  out  LINE_W  I-cache line data; valid in the i_ack cycle.
- d_req  in  1  D-cache request; held high until d_ack.
- d_we  in  1  D-cache direction: 1 = line write, 0 = line read; stable while d_req is high.
- d_address  in  32  D-cache line address; stable while d_req is high.
- d_wdata  in  LINE_W  D-cache write line; stable while d_req is high.
- d_ack  out  1  one-cycle pulse; the D-cache transfer is complete.
- d_rdata  out  LINE_W  D-cache read line; valid in the d_ack cycle.
- av_address  out  32  Avalon command address.
- av_read  out  1  Avalon read command.
- av_write  out  1  Avalon write command.
- av_writedata  out  LINE_W  Avalon write line.
- av_burstcount  out  3  constant BURST.
- av_wait_data  in  1  Avalon waitrequest; a command is held while this is high.
- av_readdatavalid  in  1  read line on av_reddata is valid.
- av_reddata  in  LINE_W  Avalon read line.

Behaviour:
- All outputs are registered, except av_burstcount, which is a constant.
- Reset values:
  - av_read, av_write, i_ack, d_ack = 0.
  - av_address, av_writedata, i_rdata, d_rdata = 0.
  - state = IDLE; last_owner = D, so the I-cache wins the first tie.
- Reset asserted mid-transfer: the transfer is abandoned immediately and no ack is issued. A late av_readdatavalid arriving in IDLE is ignored.
- States: IDLE, CMD, RDWAIT, DONE.
- IDLE:
  - Samples i_req and d_req.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the requester that is not last_owner (round robin).
  - On grant: load owner, last_owner := owner, and av_address from the owner's address.
  - A D-cache write also loads av_writedata := d_wdata.
  - Assert av_read (I-cache, or D-cache read) or av_write (D-cache write) next cycle; go to CMD.
  - Grant latency: request seen at cycle N, command on the bus at cycle N+1.
- CMD:
  - Hold the command while av_wait_data = 1.
  - The command is accepted in the first cycle with av_wait_data = 0. In that cycle's next edge, deassert av_read/av_write.
  - Write: go to DONE.
  - Read: go to RDWAIT.
  - If av_readdatavalid is already high in the acceptance cycle, capture av_reddata and go to DONE directly.
- RDWAIT: on av_readdatavalid = 1, capture av_reddata into the owner's rdata register; go to DONE.
- DONE:
  - Pulse the owner's ack for exactly one cycle; return to IDLE.
  - rdata holds its value until the next capture.
  - The requester must drop req in the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- At most one outstanding Avalon transaction at any time; av_read and av_write are never both high.
- A req deasserted before ack is a protocol violation: the arbiter completes the transaction and acks anyway.
- The non-owner's request is held pending and is granted in the next IDLE. There is no starvation: round robin alternates under continuous contention.
- No arithmetic; the address passes through unmodified.

Optional Feature:
- Macro ARB_DCACHE_PRIORITY_EN.
- Defined: fixed priority, where d_req always wins a tie in IDLE; last_owner is still tracked but unused.
- Undefined: round robin as specified above.

Test Plan:
- I-cache alone: i_req = 1, i_address = 0x0000_0100; av_wait_data = 0; av_readdatavalid 3 cycles after acceptance with line 0x..DEADBEEF.
  - Required: av_read high 1 cycle, starting 1 cycle after i_req, with av_address = 0x100 and av_burstcount = 4.
  - Required: i_ack pulses once with i_rdata = that line; d_ack stays 0.
- D-cache write with stall: d_req = 1, d_we = 1, d_address = 0x200, d_wdata = pattern; av_wait_data high for 5 cycles.
  - Required: av_write and av_writedata held stable for 6 cycles; d_ack 1 cycle after acceptance; av_read stays 0.
- Simultaneous requests from reset: i_req and d_req together.
  - Required: I-cache served first, D-cache second.
  - Repeated back-to-back contention alternates I, D, I, D; with ARB_DCACHE_PRIORITY_EN defined, the D-cache always wins the tie.
- Reset during RDWAIT: assert reset for 1 cycle, then deliver av_readdatavalid.
  - Required: no ack; all outputs return to 0; a subsequent i_req completes normally.
- Readdatavalid in the acceptance cycle: av_wait_data = 0 and av_readdatavalid = 1 in the same cycle.
  - Required: ack 1 cycle later with correct data; the state machine skips RDWAIT.
- Held request after ack: i_req remains high one cycle past i_ack.
  - Required: a second read of the same address is issued.
